// File: rtl/count_seq_ctrl.sv
// Start/stop/pause sequencer for an up/down count register with one-shot and auto-reload modes.
// Optional step prescaler enabled by defining COUNT_SEQ_PRESCALE_EN.
module count_seq_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic             dir_up,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             tc_pulse,
  output logic             done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] limit;
  logic             dir;
  logic             mode;
  logic             step;
  logic             at_term;

  assign busy    = (state == ST_RUN);
  assign paused  = busy & pause;
  assign at_term = dir ? (count == limit) : (count == '0);

`ifdef COUNT_SEQ_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps;

  // Prescaler restarts with every run so the first step is a full period after start.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps <= '0;
    end else if (state == ST_IDLE) begin
      if (start && !stop) ps <= '0;
    end else if (!stop && !pause) begin
      ps <= (ps == PS_LAST) ? '0 : ps + 1'b1;
    end
  end

  assign step = (ps == PS_LAST);
`else
  assign step = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      limit    <= '0;
      dir      <= 1'b0;
      mode     <= 1'b0;
      tc_pulse <= 1'b0;
      done     <= 1'b0;
    end else begin
      tc_pulse <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            limit <= load_val;
            dir   <= dir_up;
            mode  <= auto_reload;
            count <= dir_up ? '0 : load_val;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
          end else if (!pause && step) begin
            if (at_term) begin
              tc_pulse <= 1'b1;
              if (mode) begin
                count <= dir ? '0 : limit;
              end else begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end
            end else begin
              count <= dir ? count + 1'b1 : count - 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/count_seq_ctrl.md
Name: count_seq_ctrl

Overview:
Sequencing controller for the team's synchronous up-counter datapath, extended to a programmable up/down count engine.
- Accepts start/stop/pause commands and latches a terminal value and direction at start.
- Runs the count register in one-shot or auto-reload mode.
- Reports progress with busy, terminal-count and done indications.
- Sits between a control FSM or register interface and any logic timed off counter terminal events.

Parameters:
WIDTH, 4, bit width of count register and load value
PRESCALE, 4, cycles per count step; used only when COUNT_SEQ_PRESCALE_EN is defined; legal range >= 1

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clk
start  input  1  start request; sampled in IDLE only
stop  input  1  abort request; honoured in RUN
pause  input  1  level; holds count while high in RUN
auto_reload  input  1  latched at start: 1 = periodic, 0 = one-shot
dir_up  input  1  latched at start: 1 = count up 0→limit, 0 = count down limit→0
load_val  input  WIDTH  latched at start as limit
count  output  WIDTH  current count value, registered
busy  output  1  high while in RUN, registered
paused  output  1  combinational: busy & pause
tc_pulse  output  1  one-cycle registered pulse per terminal-count event
done  output  1  one-cycle registered pulse when a one-shot run completes

Behaviour:
- Reset: state=IDLE; count=0, busy=0, tc_pulse=0, done=0; limit/dir/mode registers=0. Reset overrides every other input, including mid-run.
- States: IDLE, RUN.
- tc_pulse and done default to 0 every cycle unless set below.
- IDLE:
  - count holds its last value.
  - Edge with start=1 and stop=0: latch limit=load_val, dir=dir_up, mode=auto_reload.
  - Same edge: count <= (dir_up ? 0 : load_val); busy<=1; state<=RUN. One-cycle latency from start to first count value.
  - start=1 with stop=1 in IDLE: stop wins; remain IDLE.
- RUN, per edge, priority order:
  1. stop=1: state<=IDLE, busy<=0, count holds; no tc_pulse, no done.
  2. pause=1: count holds; state, limit and mode unchanged.
  3. count==terminal (up: count==limit; down: count==0): tc_pulse<=1.
     - mode=1: count reloads to start value (up: 0, down: limit); remain RUN.
     - mode=0: state<=IDLE, busy<=0, done<=1; count holds terminal value.
  4. Otherwise: count <= count±1, modulo 2^WIDTH arithmetic.
- start is ignored in RUN. load_val, dir_up and auto_reload changes in RUN have no effect until the next start.
- Period: terminal value is held for one cycle, so one pass spans limit+1 count values. tc_pulse rises once per pass.
- load_val=0: terminal is reached on the first RUN edge. One-shot: done one cycle after start. Auto-reload: tc_pulse every cycle, count stays 0.
- Terminal reached with pause=1: pause wins. tc_pulse fires on the first unpaused edge.

Optional Feature:
COUNT_SEQ_PRESCALE_EN
- Defined:
  - Internal prescale counter, width ceil(log2(PRESCALE)) (min 1 bit).
  - RUN rule 3/4 actions occur only on edges where the prescaler equals PRESCALE-1; the prescaler then wraps to 0. On other unpaused RUN edges it increments and count holds.
  - Prescaler clears on start and on reset; it holds while paused.
  - stop remains immediate.
- Not defined: no prescaler logic; every unpaused RUN edge steps. Equivalent to PRESCALE=1.

Test Plan:
- Reset → count=0, busy=0, tc_pulse=0, done=0. Apply reset mid-RUN at count=2 → all outputs 0 on the next edge, state IDLE.
- One-shot up, load_val=3, start pulse at edge E0 → count 0,1,2,3 at E0..E3. E4: tc_pulse=1, done=1, busy=0, count stays 3. Both pulses low at E5.
- Auto-reload down, load_val=2 → count 2,1,0,2,1,0… tc_pulse high once every 3 cycles; busy stays 1; done never asserts.
- Pause/stop: up, load_val=9, pause high for 3 cycles at count=4 → count stays 4, paused=1. Release → 5. stop at count=6 → IDLE, count=6, no done/tc. start+stop together in IDLE → stays IDLE.
- Edge cases:
  - load_val=0 one-shot → done one cycle after start.
  - WIDTH=4, load_val=15 up → reaches 15 then done, no wrap.
  - start while busy → ignored.
  - load_val changed mid-run → no effect.
- With COUNT_SEQ_PRESCALE_EN, PRESCALE=4, one-shot up, load_val=2 → count steps every 4 cycles; done 12 cycles after start.
